uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter FIFO_WIDTH_R, default 9, meaning stored word width: 8 data bits plus 1 parity-error bit.
REQ-002 SHALL provide parameter FIFO_DEPTH_R, default 16, meaning word capacity (power of two).
REQ-003 SHALL provide parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity.
REQ-004 baud_clk  input  1  bit clock; one serial bit per rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rx_in  input  1  serial line, idle high.
REQ-007 rd_en  input  1  pop request.
REQ-008 clr_err  input  1  clears the sticky error flags.
REQ-009 data_out  output  8  popped data byte, registered.
REQ-010 par_err_out  output  1  parity-error tag of the popped byte, registered.
REQ-011 RxFE  output  1  FIFO empty.
REQ-012 RxFF  output  1  FIFO full.
REQ-013 Rx_ready  output  1  equals ~RxFF; the transmitter only starts a frame while it is high.
REQ-014 frame_err  output  1  sticky: a stop bit was sampled low.
REQ-015 overrun  output  1  sticky: a good frame was dropped because the FIFO was full.

Function
REQ-016 Frame format SHALL be: start bit 0, data bits d0..d7 LSB first, parity bit, stop bit 1, with exactly one bit per baud_clk edge and no oversampling.
REQ-017 The FSM SHALL have four states: IDLE, DATA, STOP, LINE_WAIT.
REQ-018 IDLE: rx_in==0 sampled on an edge -> DATA, with bit counter cleared to 0; otherwise the FSM stays in IDLE.
REQ-019 DATA: each edge shifts rx_in into the shift register at position bit counter and increments the counter; after the 9th sample (counter==8) -> STOP.
REQ-020 STOP with rx_in==1: push the word {parity error, data[7:0]} -> IDLE.
REQ-021 STOP with rx_in==0: set frame_err, discard the word, -> LINE_WAIT.
REQ-022 LINE_WAIT: the FSM SHALL remain until rx_in==1 is sampled, then -> IDLE; a held-low line SHALL NOT retrigger frames.
REQ-023 Parity error SHALL be XOR(d7..d0, parity bit) XOR PARITY_ODD; a word with a parity error is still stored, tagged with 1.
REQ-024 A push SHALL occur on the STOP-sampling edge; RxFE SHALL fall on that same edge.
REQ-025 Back-to-back frames SHALL be accepted: a start bit sampled on the edge after STOP is received normally.
REQ-026 A pop on rd_en with RxFE==0 SHALL update data_out and par_err_out on that edge (1-cycle latency) and advance the read pointer.
REQ-027 rd_en with RxFE==1 SHALL be ignored: outputs hold and pointers are unchanged.
REQ-028 Full: a push with RxFF==1 and no pop SHALL drop the word and set overrun.
REQ-029 Push and pop on the same edge while full SHALL both succeed, leaving the count at FIFO_DEPTH_R.
REQ-030 Push and pop on the same edge while empty SHALL perform the push only; the pop is ignored.
REQ-031 Pointers SHALL be log2(FIFO_DEPTH_R) bits and wrap modulo depth; the occupancy count SHALL be log2(FIFO_DEPTH_R)+1 bits wide.
REQ-032 RxFF SHALL be count==FIFO_DEPTH_R, and RxFE SHALL be count==0, both registered.
REQ-033 clr_err SHALL clear frame_err and overrun on the next edge; a set and a clear on the same edge SHALL resolve as set.

Reset
REQ-034 rst SHALL force: IDLE state; pointers, count and bit counter 0; data_out 8'h00; par_err_out 0; RxFE 1; RxFF 0; Rx_ready 1; frame_err 0; overrun 0.
REQ-035 rst asserted mid-frame SHALL abort the frame with no push; after release, reception resumes at the next start bit.
REQ-036 Storage array contents SHALL NOT require reset.

Structure
REQ-037 The shared package uart_pkg SHALL hold: the rx state encoding, the frame length constant (9 sampled bits), the default depth 16 and the parity-mode constants.
REQ-038 FIFO storage, pointers and flags SHALL be one sub-module, rx_sync_fifo; the FSM and deserializer SHALL stay in uart_rx_fifo.

Verification
REQ-039 Frame 0xA5 with parity 0 and stop 1, then rd_en -> data_out=0xA5, par_err_out=0, RxFE returns to 1.
REQ-040 Frame 0x01 with parity 0 (even mode) -> stored; pop gives data_out=0x01, par_err_out=1.
REQ-041 Frame 0x3C with stop bit 0, line held low 5 cycles, then high, then frame 0x55 -> frame_err=1, only 0x55 stored.
REQ-042 17 good frames 0x00..0x10 with no reads -> RxFF=1 and Rx_ready=0 after the 16th, overrun=1 after the 17th, pops return 0x00..0x0F.
REQ-043 rst pulsed after the 4th data bit of frame 0xFF, then frame 0x81 -> FIFO holds only 0x81.
REQ-044 With the FIFO full, a push edge coinciding with rd_en -> count stays 16, overrun stays 0, oldest word popped.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame length,
// FIFO depth default, parity modes and the parity check helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        LINE_WAIT = 2'd3
    } rx_state_t;

    // Bits sampled after the start bit and before the stop bit: d0..d7 + parity.
    localparam int FRAME_BITS = 9;

    localparam int DEFAULT_DEPTH = 16;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    // Returns 1 when the received parity bit does not match the selected mode.
    function automatic logic parity_error(input logic [7:0] data,
                                          input logic       par_bit,
                                          input logic       odd_mode);
        return (^data) ^ par_bit ^ odd_mode;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO holding received words, with registered empty/full/ready
// flags, a registered read port and a sticky overrun flag.
module rx_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             baud_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             ready,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO_C  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_s;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic             drop_s;

    // Qualify requests: a pop needs data, a push needs room or a concurrent pop.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        drop_s    = push & full & ~pop_ok_s;
        count_s   = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_s = count_r + CNT_ONE_C;
        end else if (pop_ok_s && !push_ok_s) begin
            count_s = count_r - CNT_ONE_C;
        end else begin
            count_s = count_r;
        end
    end

    // Pointers, occupancy, flags, read register and sticky overrun.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO_C;
            rd_ptr_r <= PTR_ZERO_C;
            count_r  <= CNT_ZERO_C;
            empty    <= 1'b1;
            full     <= 1'b0;
            ready    <= 1'b1;
            overrun  <= 1'b0;
            rd_data  <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                rd_data  <= mem_r[rd_ptr_r];
            end
            count_r <= count_s;
            empty   <= (count_s == CNT_ZERO_C);
            full    <= (count_s == CNT_DEPTH_C);
            ready   <= (count_s != CNT_DEPTH_C);
            // A drop on the same edge as a clear keeps the flag set.
            if (drop_s) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge baud_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver sampling one bit per baud_clk edge, checking parity and stop
// bit, and queueing received bytes with their parity-error tag in a FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int   FIFO_WIDTH_R = 9,
    parameter int   FIFO_DEPTH_R = DEFAULT_DEPTH,
    parameter logic PARITY_ODD   = PARITY_MODE_EVEN
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       par_err_out,
    output logic       RxFE,
    output logic       RxFF,
    output logic       Rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [3:0] LAST_BIT_C = 4'(FRAME_BITS - 1);

    rx_state_t               state_r;
    rx_state_t               state_s;
    logic [3:0]              bit_cnt_r;
    logic [3:0]              bit_cnt_s;
    logic [FRAME_BITS-1:0]   shift_r;
    logic [FRAME_BITS-1:0]   shift_s;
    logic                    push_s;
    logic                    frame_set_s;
    logic                    par_err_s;
    logic [FIFO_WIDTH_R-1:0] push_word_s;
    logic [FIFO_WIDTH_R-1:0] rd_word_s;

    // Parity verdict on the captured data and parity bit, packed with the byte.
    always_comb begin
        par_err_s   = parity_error(shift_r[7:0], shift_r[8], PARITY_ODD);
        push_word_s = {par_err_s, shift_r[7:0]};
    end

    // Next-state, deserializer and push/frame-error strobes.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_in == 1'b0) begin
                    state_s   = DATA;
                    bit_cnt_s = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                shift_s[bit_cnt_r] = rx_in;
                bit_cnt_s          = bit_cnt_r + 4'd1;
                if (bit_cnt_r == LAST_BIT_C) begin
                    state_s = STOP;
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (rx_in == 1'b1) begin
                    push_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    frame_set_s = 1'b1;
                    state_s     = LINE_WAIT;
                end
            end
            LINE_WAIT: begin
                // A line stuck low must not look like a stream of start bits.
                if (rx_in == 1'b1) begin
                    state_s = IDLE;
                end else begin
                    state_s = LINE_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM and deserializer registers; reset aborts any frame in flight.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= {FRAME_BITS{1'b0}};
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
        end
    end

    // Sticky frame error; a set on the same edge as a clear wins.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (frame_set_s) begin
            frame_err <= 1'b1;
        end else if (clr_err) begin
            frame_err <= 1'b0;
        end
    end

    rx_sync_fifo #(
        .WIDTH (FIFO_WIDTH_R),
        .DEPTH (FIFO_DEPTH_R)
    ) u_fifo (
        .baud_clk  (baud_clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (rd_en),
        .clr_ovr   (clr_err),
        .rd_data   (rd_word_s),
        .empty     (RxFE),
        .full      (RxFF),
        .ready     (Rx_ready),
        .overrun   (overrun)
    );

    assign data_out    = rd_word_s[7:0];
    assign par_err_out = rd_word_s[FIFO_WIDTH_R-1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: frames are driven one bit per edge,
// outputs are sampled 1 time unit after each rising edge.
module tb_uart_rx_fifo;

    logic       baud_clk;
    logic       rst;
    logic       rx_in;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] data_out;
    logic       par_err_out;
    logic       RxFE;
    logic       RxFF;
    logic       Rx_ready;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .baud_clk    (baud_clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .rd_en       (rd_en),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .par_err_out (par_err_out),
        .RxFE        (RxFE),
        .RxFF        (RxFF),
        .Rx_ready    (Rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        tick();
    endtask

    // Drives start, d0..d7, parity and stop; rd_en/clr_err optionally high on the stop edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic pop_on_stop, input logic clr_on_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        rd_en   = pop_on_stop;
        clr_err = clr_on_stop;
        send_bit(s);
        rd_en   = 1'b0;
        clr_err = 1'b0;
        rx_in   = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_in = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        tick(); tick();
        checks++;
        if (data_out !== 8'h00 || par_err_out !== 1'b0 || RxFE !== 1'b1 || RxFF !== 1'b0 ||
            Rx_ready !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data=%h par=%b fe=%b ff=%b rdy=%b ferr=%b ovr=%b, need 00 0 1 0 1 0 0",
                     data_out, par_err_out, RxFE, RxFF, Rx_ready, frame_err, overrun);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (RxFE !== 1'b0) begin
            errors++; $display("FAIL push_edge_empty: RxFE=%b need 0", RxFE);
        end
        pop_one();
        checks++;
        if (data_out !== 8'hA5 || par_err_out !== 1'b0 || RxFE !== 1'b1) begin
            errors++;
            $display("FAIL pop_a5: data=%h par=%b fe=%b need a5 0 1", data_out, par_err_out, RxFE);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_one();
        checks++;
        if (data_out !== 8'h01 || par_err_out !== 1'b1) begin
            errors++; $display("FAIL parity_bad: data=%h par=%b need 01 1", data_out, par_err_out);
        end
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        pop_one();
        checks++;
        if (data_out !== 8'h07 || par_err_out !== 1'b0) begin
            errors++; $display("FAIL parity_good: data=%h par=%b need 07 0", data_out, par_err_out);
        end
    endtask

    task automatic test_empty_pop();
        pop_one();
        checks++;
        if (data_out !== 8'h07 || par_err_out !== 1'b0 || RxFE !== 1'b1) begin
            errors++;
            $display("FAIL empty_pop_hold: data=%h par=%b fe=%b need 07 0 1", data_out, par_err_out, RxFE);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_one();
        checks++;
        if (data_out !== 8'h5A || RxFE !== 1'b1) begin
            errors++; $display("FAIL empty_pop_ptr: data=%h fe=%b need 5a 1", data_out, RxFE);
        end
    endtask

    task automatic test_frame_err();
        // Stop bit low with clr_err on the same edge: the set must win.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b1 || RxFE !== 1'b1) begin
            errors++; $display("FAIL frame_err_set: ferr=%b fe=%b need 1 1", frame_err, RxFE);
        end
        rx_in = 1'b0;
        repeat (5) tick();
        rx_in = 1'b1;
        tick();
        checks++;
        if (RxFE !== 1'b1) begin
            errors++; $display("FAIL held_low_retrigger: RxFE=%b need 1", RxFE);
        end
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_one();
        checks++;
        if (data_out !== 8'h55 || par_err_out !== 1'b0 || RxFE !== 1'b1) begin
            errors++;
            $display("FAIL after_frame_err: data=%h par=%b fe=%b need 55 0 1", data_out, par_err_out, RxFE);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL frame_err_clr: ferr=%b need 0", frame_err);
        end
    endtask

    task automatic test_back_to_back();
        // Push and pop on the same edge while empty: only the push happens.
        send_frame(8'h9C, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (data_out !== 8'h55 || RxFE !== 1'b0) begin
            errors++; $display("FAIL empty_push_pop: data=%h fe=%b need 55 0", data_out, RxFE);
        end
        pop_one();
        checks++;
        if (data_out !== 8'h9C || RxFE !== 1'b1) begin
            errors++; $display("FAIL empty_push_pop_word: data=%h fe=%b need 9c 1", data_out, RxFE);
        end
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1'b0);
        pop_one();
        checks++;
        if (data_out !== 8'h12 || par_err_out !== 1'b0 || RxFE !== 1'b0) begin
            errors++; $display("FAIL b2b_first: data=%h par=%b fe=%b need 12 0 0", data_out, par_err_out, RxFE);
        end
        pop_one();
        checks++;
        if (data_out !== 8'h34 || par_err_out !== 1'b0 || RxFE !== 1'b1) begin
            errors++; $display("FAIL b2b_second: data=%h par=%b fe=%b need 34 0 1", data_out, par_err_out, RxFE);
        end
    endtask

    task automatic test_full();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 8'(i);
            send_frame(v, ^v, 1'b1, 1'b0, 1'b0);
            if (i == 14) begin
                checks++;
                if (RxFF !== 1'b0 || Rx_ready !== 1'b1) begin
                    errors++; $display("FAIL not_full_15: ff=%b rdy=%b need 0 1", RxFF, Rx_ready);
                end
            end
        end
        checks++;
        if (RxFF !== 1'b1 || Rx_ready !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL full_16: ff=%b rdy=%b ovr=%b need 1 0 0", RxFF, Rx_ready, overrun);
        end
        send_frame(8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || RxFF !== 1'b1) begin
            errors++; $display("FAIL overrun_17: ovr=%b ff=%b need 1 1", overrun, RxFF);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_clr: ovr=%b need 0", overrun);
        end
    endtask

    task automatic test_full_push_pop();
        send_frame(8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (data_out !== 8'h00 || RxFF !== 1'b1 || overrun !== 1'b0) begin
            errors++; $display("FAIL full_push_pop: data=%h ff=%b ovr=%b need 00 1 0", data_out, RxFF, overrun);
        end
        for (int i = 1; i < 16; i++) begin
            pop_one();
            checks++;
            if (data_out !== 8'(i) || RxFE !== 1'b0) begin
                errors++; $display("FAIL drain_%0d: data=%h fe=%b need %h 0", i, data_out, RxFE, 8'(i));
            end
        end
        pop_one();
        checks++;
        if (data_out !== 8'h20 || par_err_out !== 1'b0 || RxFE !== 1'b1) begin
            errors++; $display("FAIL drain_last: data=%h par=%b fe=%b need 20 0 1", data_out, par_err_out, RxFE);
        end
    endtask

    task automatic test_reset_midframe();
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        rst = 1'b1;
        rx_in = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00 || RxFE !== 1'b1 || Rx_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: data=%h fe=%b rdy=%b need 00 1 1", data_out, RxFE, Rx_ready);
        end
        tick();
        rst = 1'b0;
        tick(); tick();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (RxFE !== 1'b0) begin
            errors++; $display("FAIL after_reset_push: RxFE=%b need 0", RxFE);
        end
        pop_one();
        checks++;
        if (data_out !== 8'h81 || par_err_out !== 1'b0 || RxFE !== 1'b1) begin
            errors++; $display("FAIL after_reset_word: data=%h par=%b fe=%b need 81 0 1", data_out, par_err_out, RxFE);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_empty_pop();
        test_frame_err();
        test_back_to_back();
        test_full();
        test_full_push_pop();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
